// File: rtl/mux_scan_pkg.sv
// Shared definitions for the sn74ls251 scan sequencer: state encoding, channel limit
// and the legal settle-time range.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int unsigned CNT_W      = 4;
    localparam logic [2:0]  CH_LAST    = 3'd7;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;

    // Terminal settle count, clamped so an out-of-range SETTLE still builds a sane counter.
    function automatic logic [CNT_W-1:0] settle_last(input int unsigned s);
        if (s < SETTLE_MIN) return '0;
        if (s > SETTLE_MAX) return CNT_W'(SETTLE_MAX - 1);
        return CNT_W'(s - 1);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scans one sn74ls251 8-to-1 mux as an 8-bit input port (select, settle, sample, assemble).
// Optional change-detect output chg is enabled by defining MUX_SCAN_CHANGE_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter bit          IDLE_Z = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       q,
    output logic       c,
    output logic       b,
    output logic       a,
    output logic       oe,
    output logic       busy,
    output logic       valid,
    output logic [7:0] data
`ifdef MUX_SCAN_CHANGE_EN
    ,
    output logic       chg
`endif
);

    localparam logic [CNT_W-1:0] CntLast = settle_last(SETTLE);

    state_t           r_state;
    logic [2:0]       r_ch;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_sh;
    logic [2:0]       r_cba;
    logic             r_oe;
    logic             r_busy;
    logic             r_valid;
    logic [7:0]       r_data;
    logic [7:0]       w_sh_next;
`ifdef MUX_SCAN_CHANGE_EN
    logic [7:0]       r_prev;
    logic             r_chg;
`endif

    // Word including the bit sampled this cycle, so DONE sees all eight channels.
    always_comb begin
        w_sh_next       = r_sh;
        w_sh_next[r_ch] = q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_cba   <= '0;
            r_oe    <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
`ifdef MUX_SCAN_CHANGE_EN
            r_prev  <= '0;
            r_chg   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
            r_chg   <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (start | cont) begin
                        r_state <= S_SETTLE;
                        r_ch    <= '0;
                        r_cnt   <= '0;
                        r_cba   <= '0;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CntLast) r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    r_sh <= w_sh_next;
                    if (r_ch == CH_LAST) begin
                        r_state <= S_DONE;
                        r_data  <= w_sh_next;
                        r_valid <= 1'b1;
                        r_oe    <= IDLE_Z;
                        r_cba   <= '0;
`ifdef MUX_SCAN_CHANGE_EN
                        r_chg   <= (w_sh_next != r_prev);
                        r_prev  <= w_sh_next;
`endif
                    end else begin
                        r_state <= S_SETTLE;
                        r_ch    <= r_ch + 3'd1;
                        r_cba   <= r_ch + 3'd1;
                        r_cnt   <= '0;
                    end
                end
                S_DONE: begin
                    r_ch  <= '0;
                    r_cnt <= '0;
                    r_cba <= '0;
                    if (cont) begin
                        r_state <= S_SETTLE;
                        r_oe    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_oe    <= IDLE_Z;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign {c, b, a} = r_cba;
    assign oe        = r_oe;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign data      = r_data;
`ifdef MUX_SCAN_CHANGE_EN
    assign chg       = r_chg;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl driving a behavioural sn74ls251 as the input datapath.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] i_mux = 8'h00;
    wire        q;
    logic       c, b, a, oe, busy, valid;
    logic [7:0] data;
`ifdef MUX_SCAN_CHANGE_EN
    logic       chg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // sn74ls251: selected input when enabled, high impedance otherwise
    assign q = oe ? 1'bz : i_mux[{c, b, a}];

    mux_scan_ctrl #(.SETTLE(2), .IDLE_Z(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cont  (cont),
        .q     (q),
        .c     (c),
        .b     (b),
        .a     (a),
        .oe    (oe),
        .busy  (busy),
        .valid (valid),
        .data  (data)
`ifdef MUX_SCAN_CHANGE_EN
        ,
        .chg   (chg)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_checks++;
        if (oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe got %b want 1", oe); end
        n_checks++;
        if ({c, b, a} !== 3'b000) begin n_fail++; $display("FAIL reset_cba got %b want 000", {c, b, a}); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++;
        if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || oe !== 1'b1) begin
            n_fail++; $display("FAIL reset_no_scan got busy=%b oe=%b want 0 1", busy, oe);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n_valid;
        i_mux = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        // cycle 1 now; channel 4 SAMPLE is cycle 15
        repeat (14) tick();
        n_checks++;
        if ({c, b, a} !== 3'd4 || oe !== 1'b0) begin
            n_fail++; $display("FAIL midrst_pre got cba=%0d oe=%b want 4 0", {c, b, a}, oe);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (oe !== 1'b1 || busy !== 1'b0 || {c, b, a} !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_idle got oe=%b busy=%b cba=%0d want 1 0 0", oe, busy, {c, b, a});
        end
        n_checks++;
        if (data !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", data); end
        n_valid = 0;
        for (int k = 0; k < 30; k++) begin
            if (valid === 1'b1) n_valid++;
            tick();
        end
        n_checks++;
        if (n_valid != 0) begin n_fail++; $display("FAIL midrst_novalid got %0d want 0", n_valid); end
    endtask

    task automatic test_single_scan();
        logic [2:0] exp_ch;
        i_mux = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            exp_ch = 3'((cyc - 1) / 3);
            n_checks++;
            if ({c, b, a, oe, valid, busy} !== {exp_ch, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL single_step cyc=%0d got cba=%0d oe=%b valid=%b busy=%b want %0d 0 0 1",
                         cyc, {c, b, a}, oe, valid, busy, exp_ch);
            end
            tick();
        end
        n_checks++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_valid25 got valid=%b busy=%b want 1 1", valid, busy);
        end
        n_checks++;
        if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", data); end
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || oe !== 1'b1 || {c, b, a} !== 3'd0) begin
            n_fail++;
            $display("FAIL single_idle got valid=%b busy=%b oe=%b cba=%0d want 0 0 1 0",
                     valid, busy, oe, {c, b, a});
        end
    endtask

    task automatic test_continuous();
        int cyc;
        logic [7:0] exp_word [3] = '{8'h3C, 8'hC3, 8'hC3};
        i_mux = 8'h3C;
        cont  = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            cyc = 1;
            if (s == 1) i_mux = 8'hC3;
            if (s == 2) cont = 1'b0;
            while (valid !== 1'b1 && cyc < 40) begin
                tick();
                cyc++;
            end
            n_checks++;
            if (cyc != 25) begin n_fail++; $display("FAIL cont_timing scan=%0d got %0d want 25", s, cyc); end
            n_checks++;
            if (data !== exp_word[s]) begin
                n_fail++; $display("FAIL cont_data scan=%0d got %h want %h", s, data, exp_word[s]);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || oe !== 1'b1) begin
            n_fail++; $display("FAIL cont_stop got busy=%b oe=%b want 0 1", busy, oe);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_stay_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_start_busy();
        int n_valid;
        int first;
        i_mux = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_valid = 0;
        first   = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start = (cyc == 10);
            if (valid === 1'b1) begin
                n_valid++;
                if (first == 0) first = cyc;
            end
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (n_valid != 1) begin n_fail++; $display("FAIL busy_one_valid got %0d want 1", n_valid); end
        n_checks++;
        if (first != 25) begin n_fail++; $display("FAIL busy_valid_cycle got %0d want 25", first); end
        n_checks++;
        if (busy !== 1'b0 || data !== 8'h5A) begin
            n_fail++; $display("FAIL busy_end got busy=%b data=%h want 0 5a", busy, data);
        end
    endtask

`ifdef MUX_SCAN_CHANGE_EN
    task automatic test_change();
        int cyc;
        logic [7:0] words [3] = '{8'h00, 8'h00, 8'h81};
        logic       exp_chg [3] = '{1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            i_mux = words[s];
            start = 1'b1;
            tick();
            start = 1'b0;
            cyc = 1;
            while (valid !== 1'b1 && cyc < 40) begin
                tick();
                cyc++;
            end
            n_checks++;
            if (valid !== 1'b1 || chg !== exp_chg[s]) begin
                n_fail++;
                $display("FAIL chg scan=%0d got valid=%b chg=%b want 1 %b", s, valid, chg, exp_chg[s]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_scan();
        test_single_scan();
        test_continuous();
        test_start_busy();
`ifdef MUX_SCAN_CHANGE_EN
        test_change();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
